// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Owns the write side of the instruction memory used by the single-cycle
// MIPS32 core. A program arrives as a byte stream over a valid/ready
// handshake. Bytes are packed big-endian into 32-bit words and written into
// an internal word array. The unused tail of the array is then zero-filled.
// After that the core is released, and the fetch port answers the core's
// word-indexed address combinationally.
//
// Ports
//   clock       system clock; all state updates on the rising edge
//   reset_n     asynchronous active-low reset
//   in_valid    program byte valid
//   in_ready    program byte ready (high only while loading)
//   in_byte     program byte
//   in_last     final byte of the program, qualified by a transfer
//   raddr       word-indexed fetch address from the core (pc >> 2)
//   instr       instruction word for raddr (zero until the core runs)
//   core_run    high once the program is loaded and the tail zero-filled
//   word_count  words written from the stream, a partial word included
//   err         sticky protocol error (partial last word or overflow)
// ---------------------------------------------------------------------------
module imem_loader #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_byte,
    input  logic                  in_last,
    input  logic [31:0]           raddr,
    output logic [DATA_WIDTH-1:0] instr,
    output logic                  core_run,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic                  err
);

    localparam int                    DEPTH      = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              byte_cnt_q, byte_cnt_d;
    logic [ADDR_WIDTH-1:0]   word_addr_q, word_addr_d;
    logic [ADDR_WIDTH:0]     word_count_q, word_count_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   asm_q, asm_d;
    logic                    mem_we;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // Next-state and output logic
    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        word_addr_d  = word_addr_q;
        word_count_d = word_count_q;
        err_d        = err_q;
        asm_d        = asm_q;
        mem_we       = 1'b0;
        mem_wdata    = '0;
        in_ready     = 1'b0;
        core_run     = 1'b0;

        unique case (state_q)
            LOAD: begin
                in_ready = 1'b1;
                // in_ready is constant 1 here, so in_valid alone marks a transfer.
                if (in_valid) begin
                    if (word_count_q == FULL_COUNT) begin
                        // Array is full: swallow bytes so the stream can drain to in_last.
                        err_d = 1'b1;
                        if (in_last) begin
                            state_d = RUN;
                        end
                    end else begin
                        // Byte 0 clears the lower bytes so a short last word
                        // is zero-padded without a separate mask.
                        case (byte_cnt_q)
                            2'd0:    asm_d = {in_byte, 24'h0};
                            2'd1:    asm_d = {asm_q[31:24], in_byte, 16'h0};
                            2'd2:    asm_d = {asm_q[31:16], in_byte, 8'h0};
                            default: asm_d = {asm_q[31:8], in_byte};
                        endcase
                        byte_cnt_d = byte_cnt_q + 2'd1;

                        if (byte_cnt_q == 2'd3 || in_last) begin
                            mem_we       = 1'b1;
                            mem_wdata    = asm_d;
                            word_addr_d  = word_addr_q + 1'b1;
                            word_count_d = word_count_q + 1'b1;
                            byte_cnt_d   = 2'd0;
                        end

                        if (in_last) begin
                            if (byte_cnt_q != 2'd3) begin
                                err_d = 1'b1;
                            end
                            state_d = (word_count_d < FULL_COUNT) ? FILL : RUN;
                        end
                    end
                end
            end

            FILL: begin
                mem_we      = 1'b1;
                mem_wdata   = '0;
                word_addr_d = word_addr_q + 1'b1;
                if (word_addr_q == LAST_ADDR) begin
                    state_d = RUN;
                end
            end

            RUN: begin
                core_run = 1'b1;
            end

            default: begin
                state_d = LOAD;
            end
        endcase
    end

    // Control registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= LOAD;
            byte_cnt_q   <= 2'd0;
            word_addr_q  <= '0;
            word_count_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            word_addr_q  <= word_addr_d;
            word_count_q <= word_count_d;
            err_q        <= err_d;
        end
    end

    // Datapath registers: assembly word and memory array, not reset
    always_ff @(posedge clock) begin
        asm_q <= asm_d;
        if (mem_we) begin
            mem[word_addr_q] <= mem_wdata;
        end
    end

    // Fetch port: a NOP until the core runs, and for addresses past the array.
    assign instr = (state_q == RUN && raddr[31:ADDR_WIDTH] == '0)
                   ? mem[raddr[ADDR_WIDTH-1:0]] : '0;

    assign word_count = word_count_q;
    assign err        = err_q;

endmodule
